// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (ALU, load return) and the arbiter,
// plus the register-file write port and the pending-write tag the arbiter drives.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] Write_reg;
  logic [DATA_W-1:0] Write_data;
  logic              wb_pending;
  logic [ADDR_W-1:0] wb_pending_reg;

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    output alu_ready, mem_ready,
    output RegWrite, Write_reg, Write_data,
    output wb_pending, wb_pending_reg
  );

  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    input  alu_ready, mem_ready,
    input  RegWrite, Write_reg, Write_data,
    input  wb_pending, wb_pending_reg
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU writeback
// and load return; one registered output stage plus saturating per-source counters.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_wb_arbiter_if.slave bus,
  output logic [CNT_W-1:0] alu_cnt,
  output logic [CNT_W-1:0] mem_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic {
    PTR_MEM = 1'b0,
    PTR_ALU = 1'b1
  } ptr_t;

  ptr_t              ptr_r;
  ptr_t              ptr_nxt_s;
  logic              both_s;
  logic              conflict_s;
  logic              alu_grant_s;
  logic              mem_grant_s;
  logic              accept_s;
  logic [ADDR_W-1:0] win_reg_s;
  logic [DATA_W-1:0] win_data_s;

  logic              reg_write_r;
  logic [ADDR_W-1:0] write_reg_r;
  logic [DATA_W-1:0] write_data_r;
  logic              src_alu_r;
  logic [CNT_W-1:0]  alu_cnt_r;
  logic [CNT_W-1:0]  mem_cnt_r;
  logic [CNT_W-1:0]  drop_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      sat_inc = c;
    end else begin
      sat_inc = c + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Grant selection: a same-index pair always goes to MEM first so the ALU value lands last.
  always_comb begin
    both_s      = bus.alu_valid && bus.mem_valid;
    conflict_s  = both_s && (bus.alu_reg == bus.mem_reg);
    alu_grant_s = 1'b0;
    mem_grant_s = 1'b0;
    ptr_nxt_s   = ptr_r;
    if (!rst_n) begin
      alu_grant_s = 1'b0;
      mem_grant_s = 1'b0;
    end else if (conflict_s) begin
      mem_grant_s = 1'b1;
    end else if (both_s) begin
      if (ptr_r == PTR_MEM) begin
        mem_grant_s = 1'b1;
        ptr_nxt_s   = PTR_ALU;
      end else begin
        alu_grant_s = 1'b1;
        ptr_nxt_s   = PTR_MEM;
      end
    end else if (bus.alu_valid) begin
      alu_grant_s = 1'b1;
    end else if (bus.mem_valid) begin
      mem_grant_s = 1'b1;
    end else begin
      ptr_nxt_s = ptr_r;
    end
    accept_s   = alu_grant_s || mem_grant_s;
    win_reg_s  = mem_grant_s ? bus.mem_reg  : bus.alu_reg;
    win_data_s = mem_grant_s ? bus.mem_data : bus.alu_data;
  end

  // Pointer and single write stage; writes to register 0 leave the stage holding its old index/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r        <= PTR_MEM;
      reg_write_r  <= 1'b0;
      write_reg_r  <= {ADDR_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
      src_alu_r    <= 1'b0;
    end else begin
      ptr_r <= ptr_nxt_s;
      if (accept_s && (win_reg_s != {ADDR_W{1'b0}})) begin
        reg_write_r  <= 1'b1;
        write_reg_r  <= win_reg_s;
        write_data_r <= win_data_s;
        src_alu_r    <= alu_grant_s;
      end else begin
        reg_write_r  <= 1'b0;
      end
    end
  end

  // Saturating event counters: issued writes by source, discarded register-0 writes on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_cnt_r  <= {CNT_W{1'b0}};
      mem_cnt_r  <= {CNT_W{1'b0}};
      drop_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (reg_write_r && src_alu_r) begin
        alu_cnt_r <= sat_inc(alu_cnt_r);
      end else begin
        alu_cnt_r <= alu_cnt_r;
      end
      if (reg_write_r && !src_alu_r) begin
        mem_cnt_r <= sat_inc(mem_cnt_r);
      end else begin
        mem_cnt_r <= mem_cnt_r;
      end
      if (accept_s && (win_reg_s == {ADDR_W{1'b0}})) begin
        drop_cnt_r <= sat_inc(drop_cnt_r);
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  assign bus.alu_ready      = alu_grant_s;
  assign bus.mem_ready      = mem_grant_s;
  assign bus.RegWrite       = reg_write_r;
  assign bus.Write_reg      = write_reg_r;
  assign bus.Write_data     = write_data_r;
  assign bus.wb_pending     = reg_write_r;
  assign bus.wb_pending_reg = reg_write_r ? write_reg_r : {ADDR_W{1'b0}};
  assign alu_cnt            = alu_cnt_r;
  assign mem_cnt            = mem_cnt_r;
  assign drop_cnt           = drop_cnt_r;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (RegWrite / Write_reg / Write_data) between two writeback requesters: the ALU writeback path and the memory/load return path.
- Arbitrates with round-robin priority and handshakes valid/ready with each requester.
- Registers the winning write for exactly one cycle.
- Exports a pending-write tag so downstream read logic can detect in-flight writes.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register index.
- CNT_W, 16, width of the per-requester accepted-write counters (saturating).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_reg  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- mem_valid  in  1  load-return writeback request.
- mem_ready  out  1  load request accepted this cycle.
- mem_reg  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- RegWrite  out  1  register-file write enable.
- Write_reg  out  ADDR_W  register-file write index.
- Write_data  out  DATA_W  register-file write data.
- wb_pending  out  1  a write is accepted but not yet retired (equals RegWrite).
- wb_pending_reg  out  ADDR_W  index of that write.
- alu_cnt  out  CNT_W  ALU writes issued to the register file.
- mem_cnt  out  CNT_W  load writes issued to the register file.
- drop_cnt  out  CNT_W  accepted writes discarded because they target register 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - RegWrite=0; Write_reg=0; Write_data=0; wb_pending=0; wb_pending_reg=0.
  - All counters 0; round-robin pointer = MEM-first.
  - alu_ready and mem_ready are 0 while rst_n is low.
- Reset mid-operation: an accepted but unissued write is lost; RegWrite is forced to 0 immediately.
- Handshake:
  - A transfer occurs when valid && ready.
  - ready is combinational from both valids, the pointer and the register-conflict rule. It is never conditional on its own port's ready.
  - A requester holds valid, reg and data stable until accepted.
- Single request (only one valid): that port's ready=1.
- Both requests, different registers: the port selected by the pointer wins. The pointer then flips to the other port. The loser stays pending and wins the next cycle if still valid.
- Both requests, same register index (nonzero):
  - MEM always wins, regardless of the pointer; the pointer is not changed.
  - ALU is accepted next cycle, so the final register value is the ALU data.
- Both requests targeting register 0: handled like the same-register case for arbitration.
- Pointer: updates only on a cycle where both valids are high and the requests are non-conflicting.
- Latency: a transfer accepted at edge N drives RegWrite=1, Write_reg and Write_data during cycle N+1, for exactly one cycle. Throughput is one write per cycle.
- Register 0:
  - An accepted request with reg==0 completes the handshake normally.
  - The following cycle RegWrite stays 0 and Write_reg/Write_data hold their previous values.
  - drop_cnt increments; alu_cnt/mem_cnt do not.
- wb_pending/wb_pending_reg mirror RegWrite/Write_reg in the same cycle. wb_pending_reg=0 when wb_pending=0.
- Counters:
  - Increment in the cycle RegWrite is asserted, by source.
  - Saturate at all-ones and do not wrap.
- Only the state elements listed above exist: pointer, one output stage, counters.

Test Plan:
- Reset: drive all inputs active with rst_n=0 → RegWrite=0, both ready=0, all counters 0. Release reset → at the first edge mem_ready=1, alu_ready=0.
- Single ALU write: alu_valid=1, reg=5, data=0x1234_5678 accepted at edge N → cycle N+1 has RegWrite=1, Write_reg=5, Write_data=0x12345678; cycle N+2 has RegWrite=0; alu_cnt=1.
- Round-robin: both valid continuously for 4 cycles, ALU reg=3, MEM reg=7, after reset → grants alternate MEM, ALU, MEM, ALU. Write_reg sequence is 7, 3, 7, 3.
- Same-register conflict: both valid, reg=9, alu_data=0xA, mem_data=0xB → MEM wins first (Write_data=0xB), then ALU (0xA); final reg9=0xA; pointer unchanged.
- Register-0 drop: mem_valid, reg=0, data=0xFFFF_FFFF → mem_ready=1, RegWrite stays 0 the next cycle, drop_cnt=1, mem_cnt=0.
- Counter saturation with CNT_W=2: issue 5 ALU writes to reg=1 → alu_cnt reads 1, 2, 3, 3, 3.
